// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port data memory.
// Port 0 is the CPU load/store path, port 1 the secondary (debug/DMA) master.
module dmem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic [CNT_W-1:0]  lat_cnt;
    logic              lat_done;
    logic              lat_we;
    logic              lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              grant_any;
    logic              grant_id;
    logic              accept;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_any = req0_valid || req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign lat_done = (lat_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !grant_id;
                req1_ready = req1_valid && grant_id;
                accept     = grant_any;
                if (grant_any) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_read  = ~lat_we;
                mem_write = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if (lat_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Response data registers only change on their own port's pulse, so they hold between acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_cnt    <= '0;
            lat_we     <= 1'b0;
            lat_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (accept) begin
                lat_id     <= grant_id;
                last_grant <= grant_id;
                lat_cnt    <= '0;
                lat_we     <= grant_id ? req1_we    : req0_we;
                lat_addr   <= grant_id ? req1_addr  : req0_addr;
                lat_wdata  <= grant_id ? req1_wdata : req0_wdata;
            end
            if (state == ACCESS) begin
                lat_cnt <= lat_cnt + 1'b1;
                if (lat_done) begin
                    if (lat_id) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= lat_we ? '0 : mem_rdata;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= lat_we ? '0 : mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each in front of its own bench memory, checked against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TXN_PER_PORT = 24;

    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          mem_init;
    logic          rst       [2];
    logic          in_valid  [2][2];
    logic          in_ready  [2][2];
    logic          in_we     [2][2];
    logic [AW-1:0] in_addr   [2][2];
    logic [DW-1:0] in_wdata  [2][2];
    logic          out_valid [2][2];
    logic [DW-1:0] out_rdata [2][2];
    logic          mem_read  [2];
    logic          mem_write [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic [DW-1:0] mem       [2][256];

    int checks = 0;
    int errors = 0;

    int            cyc = 0;
    int            busy         [2];
    logic          last_grant_m [2];
    logic          cur_we       [2];
    logic [AW-1:0] cur_addr     [2];
    logic [DW-1:0] cur_wdata    [2];
    logic [DW-1:0] hold         [2][2];
    logic [DW-1:0] ref_mem      [2][256];
    exp_t          exp_q0[$];
    exp_t          exp_q1[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst[0]),
        .req0_valid(in_valid[0][0]), .req0_ready(in_ready[0][0]), .req0_we(in_we[0][0]),
        .req0_addr(in_addr[0][0]), .req0_wdata(in_wdata[0][0]),
        .req1_valid(in_valid[0][1]), .req1_ready(in_ready[0][1]), .req1_we(in_we[0][1]),
        .req1_addr(in_addr[0][1]), .req1_wdata(in_wdata[0][1]),
        .rsp0_valid(out_valid[0][0]), .rsp0_rdata(out_rdata[0][0]),
        .rsp1_valid(out_valid[0][1]), .rsp1_rdata(out_rdata[0][1]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_lat3 (
        .clk(clk), .rst(rst[1]),
        .req0_valid(in_valid[1][0]), .req0_ready(in_ready[1][0]), .req0_we(in_we[1][0]),
        .req0_addr(in_addr[1][0]), .req0_wdata(in_wdata[1][0]),
        .req1_valid(in_valid[1][1]), .req1_ready(in_ready[1][1]), .req1_we(in_we[1][1]),
        .req1_addr(in_addr[1][1]), .req1_wdata(in_wdata[1][1]),
        .rsp0_valid(out_valid[1][0]), .rsp0_rdata(out_rdata[1][0]),
        .rsp1_valid(out_valid[1][1]), .rsp1_rdata(out_rdata[1][1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 3) return 32'h0000_1234;
        if (a == 5) return 32'hA5A5_0001;
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Round-robin rule: a lone requester wins, a tie goes to the one that did not win last.
    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int qfront_due(input int d);
        return (d == 0) ? exp_q0[0].due : exp_q1[0].due;
    endfunction

    function automatic exp_t qpop(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Bench-side single-port memory; its contents survive arbiter resets.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) begin
                if (mem_init) mem[d][a] <= init_word(a);
            end
            if (!mem_init && mem_write[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
        end
    end

    assign mem_rdata[0] = mem[0][mem_addr[0]];
    assign mem_rdata[1] = mem[1][mem_addr[1]];

    task automatic checkOutput(input string name, input int d, input logic [63:0] got,
                               input logic [63:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s (dut%0d, cycle %0d): got 0x%0h, expected 0x%0h",
                     name, d, cyc, got, expected);
        end
    endtask

    // Transaction model: on each edge decides who is accepted and what the reply must be.
    initial begin
        int   g;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            busy[d]         = 0;
            last_grant_m[d] = 1'b1;
            cur_we[d]       = 1'b0;
            cur_addr[d]     = '0;
            cur_wdata[d]    = '0;
        end
        forever begin
            @(posedge clk);
            if (mem_init) begin
                for (int d = 0; d < 2; d++)
                    for (int a = 0; a < 256; a++) ref_mem[d][a] = init_word(a);
            end
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    busy[d]         = 0;
                    last_grant_m[d] = 1'b1;
                end else if (busy[d] > 0) begin
                    busy[d]--;
                end else begin
                    g = pick(in_valid[d][0], in_valid[d][1], last_grant_m[d]);
                    if (g >= 0) begin
                        last_grant_m[d] = (g == 1);
                        cur_we[d]    = in_we[d][g];
                        cur_addr[d]  = in_addr[d][g];
                        cur_wdata[d] = in_wdata[d][g];
                        e.id  = g;
                        e.due = cyc + lat_of(d) + 1;
                        if (cur_we[d]) begin
                            ref_mem[d][cur_addr[d]] = cur_wdata[d];
                            e.rdata = '0;
                        end else begin
                            e.rdata = ref_mem[d][cur_addr[d]];
                        end
                        if (d == 0) exp_q0.push_back(e);
                        else        exp_q1.push_back(e);
                        busy[d] = lat_of(d) + 1;
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor: mid-cycle comparison of ready, memory-side outputs and responses.
    initial begin
        exp_t e;
        int   g;
        int   pulses;
        logic acc;
        logic exp_pulse;
        for (int d = 0; d < 2; d++) begin
            hold[d][0] = '0;
            hold[d][1] = '0;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    if (d == 0) exp_q0.delete();
                    else        exp_q1.delete();
                    hold[d][0] = '0;
                    hold[d][1] = '0;
                end else begin
                    g = (busy[d] == 0) ? pick(in_valid[d][0], in_valid[d][1], last_grant_m[d]) : -1;
                    checkOutput("req0_ready", d, 64'(in_ready[d][0]), 64'(g == 0));
                    checkOutput("req1_ready", d, 64'(in_ready[d][1]), 64'(g == 1));
                    acc = (busy[d] >= 2);
                    checkOutput("mem_read", d, 64'(mem_read[d]), 64'(acc && !cur_we[d]));
                    checkOutput("mem_write", d, 64'(mem_write[d]), 64'(acc && cur_we[d]));
                    checkOutput("mem_addr", d, 64'(mem_addr[d]), acc ? 64'(cur_addr[d]) : 64'd0);
                    checkOutput("mem_wdata", d, 64'(mem_wdata[d]), acc ? 64'(cur_wdata[d]) : 64'd0);
                    pulses    = int'(out_valid[d][0]) + int'(out_valid[d][1]);
                    exp_pulse = (qsize(d) != 0) && (qfront_due(d) <= cyc);
                    checkOutput("rsp_pulse_count", d, 64'(pulses), exp_pulse ? 64'd1 : 64'd0);
                    if (exp_pulse) begin
                        e = qpop(d);
                        if (pulses == 1) begin
                            checkOutput("rsp_port", d, 64'(out_valid[d][1]), 64'(e.id));
                            checkOutput("rsp_rdata", d, 64'(out_rdata[d][e.id]), 64'(e.rdata));
                        end
                        hold[d][e.id] = e.rdata;
                    end
                    for (int p = 0; p < 2; p++) begin
                        if (!out_valid[d][p])
                            checkOutput($sformatf("rsp%0d_rdata_hold", p), d,
                                        64'(out_rdata[d][p]), 64'(hold[d][p]));
                    end
                end
            end
        end
    end

    task automatic releasePort(input int d, input int p);
        in_valid[d][p] = 1'b0;
        in_we[d][p]    = 1'b0;
        in_addr[d][p]  = '0;
        in_wdata[d][p] = '0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic applyStimulus(input int d, input int p, input logic we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int waited = 0;
        in_valid[d][p] = 1'b1;
        in_we[d][p]    = we;
        in_addr[d][p]  = addr;
        in_wdata[d][p] = wdata;
        #1;
        while (!in_ready[d][p] && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput($sformatf("accepted_port%0d", p), d, 64'(in_ready[d][p]), 64'd1);
        @(negedge clk);
    endtask

    task automatic waitIdle(input int d);
        int n = 0;
        while ((qsize(d) != 0 || busy[d] != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic resetCheck(input int d);
        checkOutput("reset_req0_ready", d, 64'(in_ready[d][0]), 64'd0);
        checkOutput("reset_req1_ready", d, 64'(in_ready[d][1]), 64'd0);
        checkOutput("reset_rsp0_valid", d, 64'(out_valid[d][0]), 64'd0);
        checkOutput("reset_rsp1_valid", d, 64'(out_valid[d][1]), 64'd0);
        checkOutput("reset_rsp0_rdata", d, 64'(out_rdata[d][0]), 64'd0);
        checkOutput("reset_rsp1_rdata", d, 64'(out_rdata[d][1]), 64'd0);
        checkOutput("reset_mem_read", d, 64'(mem_read[d]), 64'd0);
        checkOutput("reset_mem_write", d, 64'(mem_write[d]), 64'd0);
        checkOutput("reset_mem_addr", d, 64'(mem_addr[d]), 64'd0);
        checkOutput("reset_mem_wdata", d, 64'(mem_wdata[d]), 64'd0);
    endtask

    task automatic randomTraffic(input int d, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(d, p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            releasePort(d, p);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            for (int p = 0; p < 2; p++) releasePort(d, p);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        resetCheck(0);
        resetCheck(1);
        mem_init = 1'b0;
        rst[0]   = 1'b0;
        rst[1]   = 1'b0;

        $display("[TB] single reads");
        applyStimulus(0, 0, 1'b0, 8'd5, '0);
        releasePort(0, 0);
        waitIdle(0);
        applyStimulus(1, 0, 1'b0, 8'd3, '0);
        releasePort(1, 0);
        waitIdle(1);

        $display("[TB] write then read back on port 1");
        applyStimulus(0, 1, 1'b1, 8'd8, 32'hDEAD_BEEF);
        releasePort(0, 1);
        waitIdle(0);
        applyStimulus(0, 1, 1'b0, 8'd8, '0);
        releasePort(0, 1);
        waitIdle(0);
        applyStimulus(1, 1, 1'b1, 8'h20, 32'h5555_AAAA);
        releasePort(1, 1);
        waitIdle(1);
        applyStimulus(1, 0, 1'b0, 8'h20, '0);
        releasePort(1, 0);
        waitIdle(1);

        $display("[TB] continuous contention");
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1'b0, 8'd1, '0);
            end
            begin
                for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1'b0, 8'd2, '0);
            end
        join
        releasePort(0, 0);
        releasePort(0, 1);
        waitIdle(0);

        $display("[TB] reset during access");
        applyStimulus(0, 0, 1'b0, 8'h0A, '0);
        rst[0] = 1'b1;
        releasePort(0, 0);
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        applyStimulus(0, 1, 1'b0, 8'd8, '0);
        releasePort(0, 1);
        waitIdle(0);
        applyStimulus(1, 0, 1'b0, 8'd3, '0);
        releasePort(1, 0);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        applyStimulus(1, 1, 1'b0, 8'h20, '0);
        releasePort(1, 1);
        waitIdle(1);

        $display("[TB] randomized traffic");
        fork
            randomTraffic(0, 0, TXN_PER_PORT);
            randomTraffic(0, 1, TXN_PER_PORT);
            randomTraffic(1, 0, TXN_PER_PORT);
            randomTraffic(1, 1, TXN_PER_PORT);
        join
        waitIdle(0);
        waitIdle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
